// File: rtl/spacing_buffer.sv
// Elastic FIFO that re-times a bursty sample stream so that
// successive out_nd pulses are at least SPACING cycles apart.
module spacing_buffer #(
  parameter int WDTH      = 32,
  parameter int MWDTH     = 1,
  parameter int LOG_DEPTH = 4,
  parameter int SPACING   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WDTH-1:0]      in_data,
  input  logic                 in_nd,
  input  logic [MWDTH-1:0]     in_m,
  output logic [WDTH-1:0]      out_data,
  output logic                 out_nd,
  output logic [MWDTH-1:0]     out_m,
  output logic [LOG_DEPTH:0]   count,
  output logic                 error
);

  localparam int DEPTH = 1 << LOG_DEPTH;
  localparam int EW    = WDTH + MWDTH;
  localparam int GW    = (SPACING > 1) ? $clog2(SPACING) : 1;

  localparam logic [GW-1:0]      GAP_RELOAD = GW'(SPACING - 1);
  localparam logic [LOG_DEPTH:0] FULL_CNT   = (LOG_DEPTH + 1)'(DEPTH);

  logic [EW-1:0]        mem_q [DEPTH];

  logic [LOG_DEPTH-1:0] wptr_q, wptr_d;
  logic [LOG_DEPTH-1:0] rptr_q, rptr_d;
  logic [LOG_DEPTH:0]   count_q, count_d;
  logic [GW-1:0]        gap_q, gap_d;
  logic [WDTH-1:0]      data_q, data_d;
  logic [MWDTH-1:0]     m_q, m_d;
  logic                 nd_q, nd_d;
  logic                 err_q, err_d;

  logic                 rd;
  logic                 wr;
  logic                 full;
  logic [EW-1:0]        head;

  assign head = mem_q[rptr_q];

  always_comb begin
    full = (count_q == FULL_CNT);
    rd   = (count_q != '0) && (gap_q == '0);
    // A full FIFO still takes a write when a read frees a slot.
    wr   = in_nd && (!full || rd);
  end

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    gap_d   = gap_q;
    data_d  = data_q;
    m_d     = m_q;
    nd_d    = 1'b0;
    err_d   = err_q;

    if (wr)
      wptr_d = wptr_q + 1'b1;

    if (rd) begin
      rptr_d = rptr_q + 1'b1;
      {m_d, data_d} = head;
      nd_d   = 1'b1;
      gap_d  = GAP_RELOAD;
    end else if (gap_q != '0) begin
      gap_d  = gap_q - 1'b1;
    end

    unique case (1'b1)
      (wr && !rd): count_d = count_q + 1'b1;
      (rd && !wr): count_d = count_q - 1'b1;
      default:     count_d = count_q;
    endcase

    if (in_nd && !wr)
      err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      gap_q   <= '0;
      data_q  <= '0;
      m_q     <= '0;
      nd_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      gap_q   <= gap_d;
      data_q  <= data_d;
      m_q     <= m_d;
      nd_q    <= nd_d;
      err_q   <= err_d;
    end
  end

  // Storage is not reset; pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (!rst && wr)
      mem_q[wptr_q] <= {in_m, in_data};
  end

  assign out_data = data_q;
  assign out_m    = m_q;
  assign out_nd   = nd_q;
  assign count    = count_q;
  assign error    = err_q;

endmodule
